// File: rtl/cdc_hs_rx_if.sv
// Receiver-side bundle of a 4-phase req/ack crossing: synchronized request, held source data,
// returned ack, and the captured word on a valid/ready interface.
interface cdc_hs_rx_if #(
    parameter int W = 32
);
    logic         req_sync;
    logic [W-1:0] data_async;
    logic         ack;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    modport master (
        output req_sync, data_async, out_ready,
        input  ack, out_valid, out_data
    );

    modport slave (
        input  req_sync, data_async, out_ready,
        output ack, out_valid, out_data
    );
endinterface

// File: rtl/cdc_hs_rx.sv
// Destination side of a 4-phase req/ack CDC: captures held source data, offers it valid/ready, returns ack.
// Latency: req_sync to out_valid 1 cycle; accept to ack 1 cycle. Backpressure: holds VALID while out_ready=0, ack withheld.
module cdc_hs_rx #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    cdc_hs_rx_if.slave       bus,
    output logic             busy,
    output logic             err_proto,
    output logic [CNT_W-1:0] xfer_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         capture;
    logic         accept;
    logic         viol;
    logic         ack_q;
    logic         valid_q;
    logic [W-1:0] data_q;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        accept    = 1'b0;
        viol      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_sync) begin
                    capture   = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                // A source dropping req before ack is flagged but the captured word still completes.
                viol = !bus.req_sync;
                if (bus.out_ready) begin
                    accept    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!bus.req_sync) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            busy      <= 1'b0;
            err_proto <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            ack_q   <= (state_nxt == ACK);
            valid_q <= (state_nxt == VALID);
            busy    <= (state_nxt != IDLE);
            if (capture) data_q <= bus.data_async;
            if (viol)    err_proto <= 1'b1;
            if (accept)  xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

    assign bus.ack       = ack_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
endmodule

// File: tb/tb_cdc_hs_rx.sv
// Bench for cdc_hs_rx: scoreboarded data delivery plus cycle checks of ack, errors and counters.
module tb_cdc_hs_rx;
    logic        clk;
    logic        rst;
    logic        busy_a, err_a, busy_b, err_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    int          checks;
    int          failures;
    int          exp_cnt;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;

    cdc_hs_rx_if #(.W(32)) ifa ();
    cdc_hs_rx_if #(.W(32)) ifb ();

    cdc_hs_rx #(.W(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave),
        .busy(busy_a), .err_proto(err_a), .xfer_cnt(cnt_a)
    );

    cdc_hs_rx #(.W(32), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave),
        .busy(busy_b), .err_proto(err_b), .xfer_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [31:0] d, input logic rd);
        ifa.req_sync = r; ifa.data_async = d; ifa.out_ready = rd;
        ifb.req_sync = r; ifb.data_async = d; ifb.out_ready = rd;
    endtask

    task automatic wait_ack(input logic v, input string tag);
        int n;
        n = 0;
        while (ifa.ack !== v && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, ifa.ack, v);
    endtask

    // Handshake happens at the next posedge whenever valid and ready are both high here.
    always begin
        @(negedge clk);
        #3;
        if (!rst && ifa.out_valid && ifa.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                mon_exp = sb.pop_front();
                chk("sb_data", ifa.out_data, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; exp_cnt = 0;
        rst = 1'b1;
        drv(1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ack", ifa.ack, 0);
        chk("rst_valid", ifa.out_valid, 0);
        chk("rst_data", ifa.out_data, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_cnt", cnt_a, 0);
        rst = 1'b0;

        // basic transfer
        repeat (2) @(negedge clk);
        drv(1'b1, 32'hDEADBEEF, 1'b1);
        sb.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("basic_valid", ifa.out_valid, 1);
        chk("basic_data", ifa.out_data, 32'hDEADBEEF);
        chk("basic_ack0", ifa.ack, 0);
        chk("basic_busy", busy_a, 1);
        @(negedge clk);
        exp_cnt++;
        chk("basic_ack1", ifa.ack, 1);
        chk("basic_valid0", ifa.out_valid, 0);
        chk("basic_cnt", cnt_a, exp_cnt);
        @(negedge clk);
        chk("basic_ack_hold", ifa.ack, 1);
        drv(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("basic_ack_fall", ifa.ack, 0);
        chk("basic_idle", busy_a, 0);
        chk("basic_retain", ifa.out_data, 32'hDEADBEEF);

        // consumer backpressure, with data_async changing behind the capture
        drv(1'b1, 32'hA5A55A5A, 1'b0);
        sb.push_back(32'hA5A55A5A);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", ifa.out_valid, 1);
            chk("bp_data", ifa.out_data, 32'hA5A55A5A);
            chk("bp_ack", ifa.ack, 0);
            drv(1'b1, $urandom, 1'b0);
            @(negedge clk);
        end
        drv(1'b1, 32'h0, 1'b1);
        @(negedge clk);
        exp_cnt++;
        chk("bp_ack1", ifa.ack, 1);
        chk("bp_cnt", cnt_a, exp_cnt);
        drv(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("bp_ack0", ifa.ack, 0);

        // back-to-back from a clean reset; the 2-bit counter wraps along the way
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        chk("b2b_cnt0", cnt_a, 0);
        for (int i = 1; i <= 8; i++) begin
            drv(1'b1, 32'(i), 1'b1);
            sb.push_back(32'(i));
            wait_ack(1'b1, "b2b_ack_rise");
            exp_cnt++;
            chk("b2b_cnt", cnt_a, exp_cnt);
            chk("wrap_cnt", cnt_b, exp_cnt % 4);
            drv(1'b0, 32'(i), 1'b1);
            wait_ack(1'b0, "b2b_ack_fall");
        end
        chk("b2b_total", cnt_a, 8);
        chk("b2b_err", err_a, 0);
        chk("b2b_sb_empty", sb.size(), 0);

        // req drops in the same cycle the consumer accepts
        drv(1'b1, 32'h12345678, 1'b0);
        sb.push_back(32'h12345678);
        @(negedge clk);
        chk("sim_valid", ifa.out_valid, 1);
        drv(1'b0, 32'h12345678, 1'b1);
        @(negedge clk);
        exp_cnt++;
        chk("sim_ack", ifa.ack, 1);
        chk("sim_err", err_a, 1);
        chk("sim_valid0", ifa.out_valid, 0);
        chk("sim_cnt", cnt_a, exp_cnt);
        @(negedge clk);
        chk("sim_ack0", ifa.ack, 0);
        chk("sim_idle", busy_a, 0);

        // req drops while stalled; data still delivered later
        drv(1'b1, 32'h77, 1'b0);
        sb.push_back(32'h77);
        @(negedge clk);
        chk("pe_valid", ifa.out_valid, 1);
        drv(1'b0, 32'h0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("pe_err", err_a, 1);
            chk("pe_hold_valid", ifa.out_valid, 1);
            chk("pe_hold_data", ifa.out_data, 32'h77);
            chk("pe_ack0", ifa.ack, 0);
        end
        drv(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        exp_cnt++;
        chk("pe_ack1", ifa.ack, 1);
        chk("pe_cnt", cnt_a, exp_cnt);
        @(negedge clk);
        chk("pe_ack_exit", ifa.ack, 0);
        chk("pe_sticky", err_a, 1);

        // asynchronous reset while VALID, req held high
        drv(1'b1, 32'h99, 1'b0);
        sb.push_back(32'h99);
        @(negedge clk);
        chk("rm_valid", ifa.out_valid, 1);
        #2;
        rst = 1'b1;
        drv(1'b1, 32'h55, 1'b0);
        #1;
        chk("rm_ack", ifa.ack, 0);
        chk("rm_valid0", ifa.out_valid, 0);
        chk("rm_data", ifa.out_data, 0);
        chk("rm_busy", busy_a, 0);
        chk("rm_err", err_a, 0);
        chk("rm_cnt", cnt_a, 0);
        sb.delete();
        sb.push_back(32'h55);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rm_recap_valid", ifa.out_valid, 1);
        chk("rm_recap_data", ifa.out_data, 32'h55);
        drv(1'b1, 32'h55, 1'b1);
        @(negedge clk);
        exp_cnt++;
        chk("rm_ack1", ifa.ack, 1);
        chk("rm_cnt1", cnt_a, exp_cnt);
        drv(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("rm_ack0", ifa.ack, 0);
        chk("rm_err_clear", err_a, 0);

        chk("sb_left", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
